// File: rtl/sysbus_pkg.sv
// Shared definitions for the sysbus memory responder. These include the tag field layout,
// the request encodings, the burst length and the responder state type.
package sysbus_pkg;

  localparam int unsigned TagW      = 13;
  localparam int unsigned TagRwBit  = 12;
  localparam int unsigned TagTypeHi = 11;
  localparam int unsigned TagTypeLo = 8;

  localparam logic       RwRead     = 1'b0;
  localparam logic       RwWrite    = 1'b1;
  localparam logic [3:0] TypeMemory = 4'h1;
  localparam logic [3:0] TypeMmio   = 4'h2;

  localparam int unsigned Beats = 8;
  localparam int unsigned BeatW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StRdSend,
    StWrData
  } state_e;

  function automatic logic [3:0] tag_type(input logic [TagW-1:0] tag);
    return tag[TagTypeHi:TagTypeLo];
  endfunction

  function automatic logic tag_rw(input logic [TagW-1:0] tag);
    return tag[TagRwBit];
  endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Request/response channel between a sysbus initiator (master) and the memory responder (slave).
interface sysbus_mem_responder_if;
  import sysbus_pkg::*;

  logic            reqcyc;
  logic [63:0]     req;
  logic [TagW-1:0] reqtag;
  logic            reqack;
  logic            respcyc;
  logic [63:0]     resp;
  logic [TagW-1:0] resptag;
  logic            respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );

endinterface

// File: rtl/sysbus_mem_array.sv
// 64-bit backing store with one write port and one registered read port.
// A read that hits the word being written in the same cycle returns the new data.
module sysbus_mem_array #(
  parameter int unsigned Words = 4096
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Words)-1:0] waddr_i,
  input  logic [63:0]              wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Words)-1:0] raddr_i,
  output logic [63:0]              rdata_o
);

  logic [63:0] mem_q [Words];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data only moves when re_i is set, so a stalled consumer sees a stable word.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder. It serves 8-beat line reads after a fixed latency and accepts
// 8-beat line writes into a local store. Non-memory requests are ignored.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 4
) (
  input logic                   clk,
  input logic                   reset,
  sysbus_mem_responder_if.slave bus
);

  // MEM_WORDS must be a power of two, and at least 16 so that a line field remains.
  localparam int unsigned AddrW   = $clog2(MEM_WORDS);
  localparam int unsigned LineW   = AddrW - BeatW;
  localparam logic [3:0]  LatLast = 4'(LATENCY - 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(Beats - 1);

  state_e           state_q, state_d;
  logic [LineW-1:0] line_q, line_d;
  logic [TagW-1:0]  tag_q, tag_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [3:0]       lat_q, lat_d;
  logic             reqack_q, reqack_d;

  logic             accept;
  logic             mem_we, mem_re;
  logic [AddrW-1:0] mem_waddr, mem_raddr;
  logic [63:0]      mem_rdata;

  assign accept = bus.reqcyc && (tag_type(bus.reqtag) == TypeMemory);

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    tag_d     = tag_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    reqack_d  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = {line_q, beat_q};
    mem_raddr = {line_q, beat_q};

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Line base is addr[63:6]; only the bits that index the store are kept.
          line_d   = bus.req[AddrW+2:6];
          tag_d    = bus.reqtag;
          beat_d   = '0;
          lat_d    = '0;
          reqack_d = 1'b1;
          state_d  = (tag_rw(bus.reqtag) == RwWrite) ? StWrData : StRdWait;
        end
      end

      StRdWait: begin
        if (lat_q == LatLast) begin
          // Fetch beat 0 now so it is on rdata as the state enters StRdSend.
          mem_re    = 1'b1;
          mem_raddr = {line_q, {BeatW{1'b0}}};
          lat_d     = '0;
          state_d   = StRdSend;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      StRdSend: begin
        if (bus.respack) begin
          if (beat_q == BeatLast) begin
            beat_d  = '0;
            state_d = StIdle;
          end else begin
            beat_d    = beat_q + 3'd1;
            mem_re    = 1'b1;
            mem_raddr = {line_q, beat_q + 3'd1};
          end
        end
      end

      StWrData: begin
        if (bus.reqcyc) begin
          mem_we   = 1'b1;
          reqack_d = 1'b1;
          if (beat_q == BeatLast) begin
            beat_d  = '0;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // A write or fetch that coincides with reset is abandoned along with the burst.
    if (!reset) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      line_q   <= '0;
      tag_q    <= '0;
      beat_q   <= '0;
      lat_q    <= '0;
      reqack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      tag_q    <= tag_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      reqack_q <= reqack_d;
    end
  end

  sysbus_mem_array #(
    .Words(MEM_WORDS)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(bus.req),
    .re_i   (mem_re),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  assign bus.reqack  = reqack_q;
  assign bus.respcyc = (state_q == StRdSend);
  assign bus.resp    = bus.respcyc ? mem_rdata : '0;
  assign bus.resptag = bus.respcyc ? tag_q : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: a transaction-level model is checked every cycle, plus
// hand-computed expectations for the beat values, timing and acknowledge counts.
module tb_sysbus_mem_responder;
  import sysbus_pkg::*;

  localparam int unsigned MemWords = 64;
  localparam int unsigned Lat      = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  sysbus_mem_responder_if bus ();

  sysbus_mem_responder #(
    .MEM_WORDS(MemWords),
    .LATENCY  (Lat)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory contents plus the outstanding burst, advanced once per clock edge.
  typedef enum {MIdle, MWait, MSend, MWr} mmode_e;
  mmode_e      m_mode = MIdle;
  logic [63:0] m_mem [MemWords];
  logic [63:0] m_q[$];
  int          m_cyc = 0;
  int          m_start = 0;
  int          m_base = 0;
  int          m_wn = 0;
  logic        exp_ack = 1'b0;
  logic [12:0] exp_tag = '0;
  logic        m_valid = 1'b0;
  logic        m_rst = 1'b0;

  initial for (int i = 0; i < MemWords; i++) m_mem[i] = '0;

  function automatic int widx(input logic [63:0] a);
    return int'(((a >> 3) & ~64'd7) % 64'(MemWords));
  endfunction

  always @(posedge clk) begin
    m_cyc++;
    m_valid = 1'b1;
    m_rst = !reset;
    exp_ack = 1'b0;
    if (!reset) begin
      m_mode = MIdle;
      m_q.delete();
      exp_tag = '0;
    end else begin
      case (m_mode)
        MIdle: if (bus.reqcyc && bus.reqtag[11:8] == TypeMemory) begin
          exp_ack = 1'b1;
          exp_tag = bus.reqtag;
          m_base = widx(bus.req);
          if (bus.reqtag[12] == RwRead) begin
            for (int i = 0; i < 8; i++) m_q.push_back(m_mem[(m_base + i) % MemWords]);
            m_start = m_cyc + Lat;
            m_mode = MWait;
          end else begin
            m_wn = 0;
            m_mode = MWr;
          end
        end
        MWait: if (m_cyc == m_start) m_mode = MSend;
        MSend: if (bus.respack) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_mode = MIdle;
        end
        MWr: if (bus.reqcyc) begin
          m_mem[(m_base + m_wn) % MemWords] = bus.req;
          m_wn++;
          exp_ack = 1'b1;
          if (m_wn == 8) m_mode = MIdle;
        end
        default: m_mode = MIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("reqack", 64'(bus.reqack), 64'(exp_ack));
      check("respcyc", 64'(bus.respcyc), 64'(m_mode == MSend));
      if (m_mode == MSend) begin
        check("resp", bus.resp, m_q[0]);
        check("resptag", 64'(bus.resptag), 64'(exp_tag));
      end
      if (m_rst) begin
        check("rst_resp", bus.resp, 64'd0);
        check("rst_resptag", 64'(bus.resptag), 64'd0);
      end
    end
  end

  // Observation for the literal checks.
  logic [63:0] obs[$];
  logic [63:0] stalls[$];
  int nc = 0;
  int ack_cnt = 0;
  int ack_cyc = -1;
  int first_resp = -1;
  int resp_cycles = 0;
  int beat_seen = 0;
  bit stall_en = 1'b0;
  int stall_cnt = 0;

  always @(negedge clk) begin
    nc++;
    if (bus.reqack === 1'b1) begin
      ack_cnt++;
      if (ack_cyc < 0) ack_cyc = nc;
    end
    if (bus.respcyc === 1'b1) begin
      resp_cycles++;
      if (first_resp < 0) first_resp = nc;
      if (bus.respack) begin
        obs.push_back(bus.resp);
        beat_seen++;
      end else begin
        stalls.push_back(bus.resp);
      end
    end
  end

  // Respack follows respcyc, except for optional 3-cycle stalls on beats 2 and 5.
  initial begin
    bus.respack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.respcyc && stall_en && (beat_seen == 2 || beat_seen == 5) && stall_cnt < 3) begin
        bus.respack = 1'b0;
        stall_cnt++;
      end else begin
        bus.respack = bus.respcyc;
        if (bus.respcyc) stall_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs.delete();
    stalls.delete();
    ack_cnt = 0;
    ack_cyc = -1;
    first_resp = -1;
    resp_cycles = 0;
    beat_seen = 0;
    stall_cnt = 0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] d0, input int gap_at);
    clear_obs();
    bus.reqcyc = 1'b1;
    bus.req = addr;
    bus.reqtag = {RwWrite, TypeMemory, 8'h22};
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        bus.reqcyc = 1'b0;
        tick();
      end
      bus.reqcyc = 1'b1;
      bus.req = d0 + 64'(i);
      tick();
    end
    bus.reqcyc = 1'b0;
    repeat (3) tick();
    check("wr_data_acks", 64'(ack_cnt - 1), 64'd8);
  endtask

  task automatic start_read(input logic [63:0] addr, input logic [7:0] id);
    clear_obs();
    bus.reqcyc = 1'b1;
    bus.req = addr;
    bus.reqtag = {RwRead, TypeMemory, id};
    tick();
    bus.reqcyc = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] id, input logic [63:0] d0);
    start_read(addr, id);
    for (int n = 0; n < 200 && obs.size() < 8; n++) tick();
    repeat (2) tick();
    check("rd_beats", 64'(obs.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs.size(); i++) check("rd_data", obs[i], d0 + 64'(i));
    check("rd_latency", 64'(first_resp - ack_cyc), 64'(Lat));
    check("rd_acks", 64'(ack_cnt), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    bus.reqcyc = 1'b1;
    bus.req = 64'h40;
    bus.reqtag = {RwRead, TypeMemory, 8'h01};
    reset = 1'b0;
    clear_obs();
    repeat (3) tick();
    check("rst_acks", 64'(ack_cnt), 64'd0);
    check("rst_respcyc", 64'(resp_cycles), 64'd0);
    reset = 1'b1;
    bus.reqcyc = 1'b0;
    tick();

    do_write(64'h40, 64'h10, -1);
    do_read(64'h40, 8'h05, 64'h10);
    do_read(64'h7F, 8'h06, 64'h10);

    stall_en = 1'b1;
    do_read(64'h40, 8'h07, 64'h10);
    stall_en = 1'b0;
    check("stall_respcyc", 64'(resp_cycles), 64'd14);
    check("stall_n", 64'(stalls.size()), 64'd6);
    for (int i = 0; i < 6 && i < stalls.size(); i++)
      check("stall_hold", stalls[i], (i < 3) ? 64'h12 : 64'h15);

    do_write(64'h80, 64'hA0, 4);
    do_read(64'h80, 8'h08, 64'hA0);

    start_read(64'h40, 8'h09);
    for (int n = 0; n < 100 && beat_seen < 3; n++) tick();
    check("rst_mid_reached", 64'(beat_seen >= 3), 64'd1);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    do_read(64'h40, 8'h0A, 64'h10);

    clear_obs();
    bus.reqcyc = 1'b1;
    bus.req = 64'h40;
    bus.reqtag = {RwRead, TypeMmio, 8'h0B};
    repeat (3) tick();
    bus.reqcyc = 1'b0;
    repeat (8) tick();
    check("mmio_acks", 64'(ack_cnt), 64'd0);
    check("mmio_resp", 64'(resp_cycles), 64'd0);

    do_read(64'h1040, 8'h0C, 64'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, backing store depth in 64-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from reqack to first read beat (range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port reqcyc  input  1  request valid (address beat, or write-data beat).
REQ-006 SHALL have port req  input  64  request address, or write data during write-data phase.
REQ-007 SHALL have port reqtag  input  13  {rw[12], type[11:8], id[7:0]}.
REQ-008 SHALL have port reqack  output  1  one-cycle acceptance of the current request beat.
REQ-009 SHALL have port respcyc  output  1  response beat valid.
REQ-010 SHALL have port resp  output  64  response data.
REQ-011 SHALL have port resptag  output  13  echo of accepted reqtag.
REQ-012 SHALL have port respack  input  1  initiator accepts current beat (may be combinational from respcyc).

Function
REQ-013 SHALL implement states IDLE, RD_WAIT, RD_SEND, WR_DATA.
REQ-014 SHALL in IDLE, on reqcyc=1 with type=MEMORY, register addr and tag, drive reqack=1 the next cycle for exactly one cycle, and go to RD_WAIT (rw=READ) or WR_DATA (rw=WRITE).
REQ-015 SHALL ignore requests with type!=MEMORY: no reqack, stay IDLE.
REQ-016 SHALL not accept a new request outside IDLE; reqack=0 there except per-beat acks in WR_DATA.
REQ-017 SHALL align line base = addr[63:6]; word index = (addr>>3 & ~7) mod MEM_WORDS; low 6 address bits ignored.
REQ-018 SHALL in RD_WAIT count LATENCY cycles after reqack, then enter RD_SEND with respcyc=1 carrying word base+0.
REQ-019 SHALL transfer a beat only on a cycle where respcyc=1 and respack=1; resp/resptag held stable until then.
REQ-020 SHALL deliver 8 beats, beat i = mem[base+i], beat counter 3 bits; after beat 7 transfers, respcyc=0 next cycle and state returns to IDLE.
REQ-021 SHALL permit respack stalls of any length; beat order never changes.
REQ-022 SHALL in WR_DATA accept 8 data beats: each cycle reqcyc=1 writes req to mem[base+i] and pulses reqack the following cycle; reqcyc=0 cycles are idle.
REQ-023 SHALL return to IDLE after the 8th write beat; writes produce no response beats.
REQ-024 SHALL make a write completed before a read's reqack visible to that read.
REQ-025 SHALL wrap word index modulo MEM_WORDS (no out-of-range access).

Reset
REQ-026 SHALL while reset=0: state IDLE, reqack=0, respcyc=0, resp=0, resptag=0, beat and latency counters 0.
REQ-027 SHALL abandon any in-flight read or write on reset; partially written lines keep already-written words.
REQ-028 SHALL not clear memory contents on reset.

Structure
REQ-029 SHALL take tag field positions, READ/WRITE and MEMORY/MMIO encodings, BEATS=8, and the state enum from shared package sysbus_pkg.
REQ-030 SHALL instantiate one sub-module sysbus_mem_array: 64-bit, MEM_WORDS deep, one synchronous read port, one write port, read-after-write same cycle returns new data.

Verification
REQ-031 Reset held 3 cycles with reqcyc=1 -> reqack=0, respcyc=0, resp=0 throughout.
REQ-032 Preload mem[8..15]=0x10..0x17; read req=0x40 with respack=respcyc -> reqack 1 cycle later, first beat 4 cycles after reqack, 8 consecutive beats 0x10..0x17, then IDLE.
REQ-033 Same read with req=0x7F -> identical 8 beats (low 6 bits ignored).
REQ-034 Read with respack low on beats 2 and 5 for 3 cycles each -> resp holds 0x12/0x15 stable, total 14 respcyc cycles, order intact.
REQ-035 Write to 0x80 with data 0xA0..0xA7, one idle reqcyc=0 gap, then read 0x80 -> 8 write reqacks, read returns 0xA0..0xA7.
REQ-036 Reset asserted during beat 3 of a read, then read at 0x40 -> clean restart, beats 0x10..0x17; request with type=MMIO -> no reqack.
